// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader/processor definitions.
//   WORD_W     - instruction byte width
//   DEF_ADDR_W - default instruction-memory address width (matches the IF PC)
//   state_t    - loader FSM state encoding
package imem_loader_pkg;
   localparam int WORD_W = 8;
   localparam int DEF_ADDR_W = 8;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: loader control, byte stream and instruction-memory write bus.
//   master (driver/observer side): start, in_valid, in_data out; the rest in
//   slave  (loader side): in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error out
interface imem_loader_if import imem_loader_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
   logic start;
   logic in_valid;
   logic [WORD_W-1:0] in_data;
   logic in_ready;
   logic mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic cpu_hold;
   logic done;
   logic error;
   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
   );
   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
   );
endinterface

// File: rtl/imem_loader_csum.sv
// imem_loader_csum: 8-bit modulo-256 running sum with clear and enable.
//   clock, reset - system clock, async active-high reset
//   clr          - clear sum (has priority over en)
//   en           - add data to sum
//   data, sum    - input byte, running sum
module imem_loader_csum import imem_loader_pkg::*; (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [WORD_W-1:0] data,
   output logic [WORD_W-1:0] sum
);
   always_ff @(posedge clock or posedge reset)
      if (reset) sum <= '0;
      else if (clr) sum <= '0;
      else if (en) sum <= sum + data;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length byte plus N bytes into instruction memory, holding the CPU until done.
//   clock, reset - system clock, async active-high reset
//   bus (slave)  - start pulse, valid/ready byte stream, memory write port,
//                  cpu_hold / done / error status (all outputs registered)
//   IMEM_LOADER_CHECKSUM_EN - when defined, a trailing modulo-256 checksum byte
//                  is verified after the data (CHK state); mismatch leads to ERR
module imem_loader import imem_loader_pkg::*; #(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int BASE_ADDR = 0
) (
   input logic        clock,
   input logic        reset,
   imem_loader_if.slave bus
);
   state_t state;
   logic [ADDR_W-1:0] count;
   logic [WORD_W-1:0] len;
   logic xfer;
   logic last;
   logic load_start;
   assign xfer = bus.in_valid & bus.in_ready;
   // len==0 wraps to 255 here, so a zero length means 256 bytes
   assign last = WORD_W'(count) == len - 1'b1;
   assign load_start = bus.start & (state == IDLE || state == DONE || state == ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] sum;
   imem_loader_csum u_csum (
      .clock(clock),
      .reset(reset),
      .clr  (load_start),
      .en   (xfer && state == DATA),
      .data (bus.in_data),
      .sum  (sum)
   );
`endif
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= ADDR_W'(BASE_ADDR);
         bus.mem_wdata <= '0;
         bus.cpu_hold  <= 1'b1;
         bus.done      <= 1'b0;
         bus.error     <= 1'b0;
         count         <= '0;
         len           <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         if (load_start) begin
            state        <= LEN;
            bus.in_ready <= 1'b1;
            bus.cpu_hold <= 1'b1;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
            count        <= '0;
         end else if (xfer && state == LEN) begin
            len   <= bus.in_data;
            state <= DATA;
         end else if (xfer && state == DATA) begin
            // write lands the cycle after the transfer
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ADDR_W'(BASE_ADDR) + count;
            bus.mem_wdata <= bus.in_data;
            count         <= count + 1'b1;
            if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state <= CHK;
`else
               // release the pipeline together with the final write pulse
               state        <= DONE;
               bus.in_ready <= 1'b0;
               bus.done     <= 1'b1;
               bus.cpu_hold <= 1'b0;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         else if (xfer && state == CHK) begin
            state        <= bus.in_data == sum ? DONE : ERR;
            bus.in_ready <= 1'b0;
            bus.done     <= bus.in_data == sum;
            bus.error    <= bus.in_data != sum;
            bus.cpu_hold <= bus.in_data != sum;
         end
`endif
      end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
module tb_imem_loader;
   import imem_loader_pkg::*;
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;
   int wr_count = 0;
   logic [7:0] exp_addr = '0;
   logic [7:0] sum = '0;
   wr_t exp_q[$];
   wr_t mon_e;
   logic [4:0] flags;
   imem_loader_if #(.ADDR_W(8)) bus ();
   imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );
   always #5 clock = ~clock;
   // {in_ready, mem_we, cpu_hold, done, error}
   assign flags = {bus.in_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.error};
   always @(negedge clock)
      if (!reset && bus.mem_we) begin
         checks++;
         wr_count++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_write got addr=%0h data=%0h, required no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.mem_addr, bus.mem_wdata} !== mon_e) begin
               errors++;
               $display("FAIL write got addr=%0h data=%0h, required addr=%0h data=%0h",
                        bus.mem_addr, bus.mem_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      exp_addr = '0;
      sum = '0;
   endtask
   task automatic send(input logic [7:0] b, input bit is_data);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data = b;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clock);
         #1;
         n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout in_ready=%b, required 1", bus.in_ready);
      end else if (is_data) begin
         exp_q.push_back({exp_addr, b});
         exp_addr++;
         sum += b;
      end
      @(posedge clock);
      #1;
   endtask
   task automatic end_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(sum, 1'b0);
`endif
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1;
   endtask
   task automatic check_done(input string name);
      checks++;
      if (flags !== 5'b00010) begin
         errors++;
         $display("FAIL %s_done flags=%b, required 00010", name, flags);
      end
      @(negedge clock);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain pending=%0d, required 0", name, exp_q.size());
      end
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (flags !== 5'b00100 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset flags=%b addr=%0h wdata=%0h, required 00100/0/0", flags, bus.mem_addr, bus.mem_wdata);
      end
      reset = 1'b0;
   endtask
   task automatic test_basic();
      int w0 = wr_count;
      pulse_start();
      checks++;
      if (flags !== 5'b10100) begin
         errors++;
         $display("FAIL basic_start flags=%b, required 10100", flags);
      end
      send(8'd3, 1'b0);
      send(8'hA1, 1'b1);
      checks++;
      if (bus.mem_we !== 1'b1) begin
         errors++;
         $display("FAIL basic_we0 mem_we=%b, required 1", bus.mem_we);
      end
      send(8'hB2, 1'b1);
      checks++;
      if (bus.mem_we !== 1'b1) begin
         errors++;
         $display("FAIL basic_we1 mem_we=%b, required 1", bus.mem_we);
      end
      send(8'hC3, 1'b1);
      checks++;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (flags !== 5'b11100) begin
         errors++;
         $display("FAIL basic_last flags=%b, required 11100", flags);
      end
`else
      if (flags !== 5'b01010) begin
         errors++;
         $display("FAIL basic_last flags=%b, required 01010", flags);
      end
`endif
      end_load();
      check_done("basic");
      checks++;
      if (wr_count - w0 != 3) begin
         errors++;
         $display("FAIL basic_count writes=%0d, required 3", wr_count - w0);
      end
   endtask
   task automatic test_backpressure();
      int w0 = wr_count;
      pulse_start();
      send(8'd2, 1'b0);
      send(8'h5A, 1'b1);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         checks++;
         if (bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap%0d mem_we=%b, required 0", i, bus.mem_we);
         end
      end
      send(8'h3C, 1'b1);
      end_load();
      check_done("bp");
      checks++;
      if (wr_count - w0 != 2) begin
         errors++;
         $display("FAIL bp_count writes=%0d, required 2", wr_count - w0);
      end
   endtask
   task automatic test_wrap();
      int w0 = wr_count;
      int w1;
      pulse_start();
      send(8'd0, 1'b0);
      for (int i = 0; i < 256; i++) send(8'(i), 1'b1);
      end_load();
      check_done("wrap");
      checks++;
      if (wr_count - w0 != 256 || bus.mem_addr !== 8'hFF) begin
         errors++;
         $display("FAIL wrap_end writes=%0d addr=%0h, required 256/ff", wr_count - w0, bus.mem_addr);
      end
      w1 = wr_count;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (wr_count != w1 || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL wrap_after extra_writes=%0d done=%b, required 0/1", wr_count - w1, bus.done);
      end
   endtask
   task automatic test_reset_midload();
      pulse_start();
      send(8'd5, 1'b0);
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (flags !== 5'b00100 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
         errors++;
         $display("FAIL midload_reset flags=%b addr=%0h wdata=%0h, required 00100/0/0", flags, bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL midload_pending pending=%0d, required 0", exp_q.size());
      end
      exp_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      pulse_start();
      send(8'd1, 1'b0);
      send(8'h7E, 1'b1);
      end_load();
      check_done("midload");
   endtask
   task automatic test_ignored_start();
      pulse_start();
      send(8'd4, 1'b0);
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      bus.start = 1'b1;
      send(8'h03, 1'b1);
      bus.start = 1'b0;
      checks++;
      if (flags !== 5'b11100) begin
         errors++;
         $display("FAIL ignstart_flags flags=%b, required 11100", flags);
      end
      send(8'h04, 1'b1);
      end_load();
      check_done("ignstart");
   endtask
`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int w0;
      pulse_start();
      send(8'd2, 1'b0);
      send(8'h10, 1'b1);
      send(8'h20, 1'b1);
      send(8'h30, 1'b0);
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1;
      check_done("csum_ok");
      pulse_start();
      send(8'd2, 1'b0);
      send(8'h10, 1'b1);
      send(8'h20, 1'b1);
      @(negedge clock);
      #1;
      w0 = wr_count;
      send(8'h31, 1'b0);
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (flags !== 5'b00101 || wr_count != w0) begin
         errors++;
         $display("FAIL csum_bad flags=%b writes=%0d, required 00101/0", flags, wr_count - w0);
      end
      pulse_start();
      checks++;
      if (flags !== 5'b10100) begin
         errors++;
         $display("FAIL csum_restart flags=%b, required 10100", flags);
      end
   endtask
`endif
   initial begin
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_reset_midload();
      test_ignored_start();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
